// File: rtl/sram_banked_wrapper.sv
// -----------------------------------------------------------------------------
// sram_banked_wrapper
//
// Builds one ADDR_W x DATA_W single-port memory out of ROWS x COLS 1RW macros
// (2**MACRO_ADDR_W words x MACRO_DATA_W bits each). The top address bits pick
// the row and the low MACRO_ADDR_W bits address every macro in that row. Each
// column is one MACRO_DATA_W slice of the word and has its own write mask bit.
//
// Requests use a valid/ready handshake. Read data is returned in order through
// a small response FIFO. Reads are only accepted while a FIFO slot is still
// free for them, so the FIFO can never overflow. When INIT_ZERO=1, all macros
// are cleared to zero after reset before the first request is accepted.
//
// Ports
//   RW0_clk     in   1        clock; also the CE of every macro
//   RW0_rst_n   in   1        asynchronous active-low reset
//   RW0_en      in   1        request valid
//   RW0_ready   out  1        request ready (registered)
//   RW0_addr    in   ADDR_W   word address; upper bits select the row
//   RW0_wmode   in   1        1 = write, 0 = read
//   RW0_wdata   in   DATA_W   write data
//   RW0_wmask   in   COLS     per-column write enable (ignored on reads)
//   RW0_rvalid  out  1        response valid (FIFO not empty)
//   RW0_rready  in   1        response ready
//   RW0_rdata   out  DATA_W   response data (FIFO head)
//   init_done   out  1        zero-fill complete
// -----------------------------------------------------------------------------
module sram_banked_wrapper #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 32,
   parameter int MACRO_ADDR_W   = 12,
   parameter int MACRO_DATA_W   = 16,
   parameter int RSP_DEPTH      = 4,
   parameter int INIT_ZERO      = 1,
   localparam int COLS          = DATA_W / MACRO_DATA_W
) (
   input  logic              RW0_clk,
   input  logic              RW0_rst_n,
   input  logic              RW0_en,
   output logic              RW0_ready,
   input  logic [ADDR_W-1:0] RW0_addr,
   input  logic              RW0_wmode,
   input  logic [DATA_W-1:0] RW0_wdata,
   input  logic [COLS-1:0]   RW0_wmask,
   output logic              RW0_rvalid,
   input  logic              RW0_rready,
   output logic [DATA_W-1:0] RW0_rdata,
   output logic              init_done
);

   localparam int ROW_W     = ADDR_W - MACRO_ADDR_W;
   localparam int ROWS      = 1 << ROW_W;
   localparam int ROW_SEL_W = (ROW_W > 0) ? ROW_W : 1;
   localparam int MDEPTH    = 1 << MACRO_ADDR_W;
   localparam int PTR_W     = $clog2(RSP_DEPTH);
   localparam int CRD_W     = PTR_W + 1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                  state_reg, state_next;
   logic [MACRO_ADDR_W-1:0] init_addr_reg, init_addr_next;

   logic                    ready_reg;
   logic                    init_done_reg;
   logic [CRD_W-1:0]        credits_reg, credits_next;

   // Stage 1: registered request driving the macros
   logic                    s1_v_reg;
   logic                    s1_wmode_reg;
   logic [ADDR_W-1:0]       s1_addr_reg;
   logic [DATA_W-1:0]       s1_wdata_reg;
   logic [COLS-1:0]         s1_wmask_reg;
   logic [ROW_SEL_W-1:0]    s1_row;

   // Stage 2: read in progress and the row whose outputs must be selected
   logic                    s2_v_reg;
   logic [ROW_SEL_W-1:0]    s2_row_reg;

   // Response FIFO; pointers carry one extra wrap bit
   logic [DATA_W-1:0]       fifo_mem [RSP_DEPTH];
   logic [CRD_W-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic [CRD_W-1:0]        fifo_count;

   // Macro interface (all controls active-low)
   logic [MACRO_ADDR_W-1:0]        mac_a;
   logic [DATA_W-1:0]              mac_i;
   logic [ROWS-1:0]                mac_csb;
   logic [ROWS-1:0][COLS-1:0]      mac_web;
   logic [ROWS-1:0][COLS-1:0]      mac_oeb;
   logic [MACRO_DATA_W-1:0]        mac_o [ROWS][COLS];
   logic [DATA_W-1:0]              rd_mux;

   logic accept, acc_rd, pop;

   assign accept = RW0_en & ready_reg;
   assign acc_rd = accept & ~RW0_wmode;
   assign pop    = RW0_rvalid & RW0_rready;

   generate
      if (ROW_W > 0) begin : g_row_sel
         assign s1_row = s1_addr_reg[ADDR_W-1:MACRO_ADDR_W];
      end else begin : g_one_row
         assign s1_row = '0;
      end
   endgenerate

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         state_reg     <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
         init_addr_reg <= '0;
      end else begin
         state_reg     <= state_next;
         init_addr_reg <= init_addr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      init_addr_next = init_addr_reg;
      case (state_reg)
         S_INIT: begin
            init_addr_next = init_addr_reg + 1'b1;
            if (init_addr_reg == {MACRO_ADDR_W{1'b1}}) begin
               state_next = S_RUN;
            end
         end
         default: ;
      endcase
   end

   // During init every macro is written with zero at the sweep address;
   // afterwards only the selected row is enabled by the stage-1 request.
   always_comb begin
      logic row_hit;
      row_hit = 1'b0;
      mac_a   = s1_addr_reg[MACRO_ADDR_W-1:0];
      mac_i   = s1_wdata_reg;
      mac_csb = '1;
      mac_web = '1;
      mac_oeb = '1;
      if (state_reg == S_INIT) begin
         mac_a   = init_addr_reg;
         mac_i   = '0;
         mac_csb = '0;
         mac_web = '0;
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            row_hit    = s1_v_reg && (s1_row == ROW_SEL_W'(r));
            mac_csb[r] = ~row_hit;
            for (int c = 0; c < COLS; c++) begin
               mac_web[r][c] = ~(row_hit & s1_wmode_reg & s1_wmask_reg[c]);
               mac_oeb[r][c] = ~(row_hit & ~s1_wmode_reg);
            end
         end
      end
   end

   // ------------------------------------------------------------- macros ---
   // Behavioural stand-in for the generated macro instance block: write on
   // CE with CSB=WEB=0, output register loaded on CE with CSB=OEB=0.
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
         for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic [MACRO_DATA_W-1:0] mem [MDEPTH];
            logic [MACRO_DATA_W-1:0] o_reg;

            always_ff @(posedge RW0_clk) begin
               if (!mac_csb[gi] && !mac_web[gi][gj]) begin
                  mem[mac_a] <= mac_i[gj*MACRO_DATA_W +: MACRO_DATA_W];
               end
               if (!mac_csb[gi] && !mac_oeb[gi][gj]) begin
                  o_reg <= mem[mac_a];
               end
            end

            assign mac_o[gi][gj] = o_reg;
         end
      end
   endgenerate

   // Select the COLS outputs of the row that was read one cycle earlier.
   always_comb begin
      rd_mux = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (s2_row_reg == ROW_SEL_W'(r)) begin
               rd_mux[c*MACRO_DATA_W +: MACRO_DATA_W] = mac_o[r][c];
            end
         end
      end
   end

   // ---------------------------------------------------- control / pipe ---
   assign credits_next = credits_reg + CRD_W'(acc_rd) - CRD_W'(pop);

   always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) begin
         ready_reg     <= 1'b0;
         init_done_reg <= (INIT_ZERO == 0);
         credits_reg   <= '0;
         s1_v_reg      <= 1'b0;
         s1_wmode_reg  <= 1'b0;
         s1_addr_reg   <= '0;
         s1_wdata_reg  <= '0;
         s1_wmask_reg  <= '0;
         s2_v_reg      <= 1'b0;
         s2_row_reg    <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
      end else begin
         // Ready is computed from next-cycle state so it is registered yet
         // still drops in the same cycle the last credit is taken.
         ready_reg     <= (state_next == S_RUN) && (credits_next < CRD_W'(RSP_DEPTH));
         init_done_reg <= (state_reg == S_RUN);
         credits_reg   <= credits_next;

         s1_v_reg <= accept;
         if (accept) begin
            s1_wmode_reg <= RW0_wmode;
            s1_addr_reg  <= RW0_addr;
            s1_wdata_reg <= RW0_wdata;
            s1_wmask_reg <= RW0_wmask;
         end

         s2_v_reg   <= s1_v_reg & ~s1_wmode_reg;
         s2_row_reg <= s1_row;

         // The FIFO slot itself serves as the output register, so a read
         // is visible at the FIFO head three cycles after acceptance.
         if (s2_v_reg) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge RW0_clk) begin
      if (s2_v_reg) begin
         fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= rd_mux;
      end
   end

   assign fifo_count = wr_ptr_reg - rd_ptr_reg;

   // Credits bound in-flight reads plus stored responses, so a push always
   // finds a free slot.
   assert property (@(posedge RW0_clk) disable iff (!RW0_rst_n)
                    s2_v_reg |-> (fifo_count < CRD_W'(RSP_DEPTH)));

   assign RW0_ready  = ready_reg;
   assign init_done  = init_done_reg;
   assign RW0_rvalid = (wr_ptr_reg != rd_ptr_reg);
   assign RW0_rdata  = RW0_rvalid ? fifo_mem[rd_ptr_reg[PTR_W-1:0]] : '0;

endmodule

// File: tb/tb_sram_banked_wrapper.sv
// -----------------------------------------------------------------------------
// Testbench for sram_banked_wrapper (ADDR_W=6, MACRO_ADDR_W=4, DATA_W=32,
// MACRO_DATA_W=16, RSP_DEPTH=4, INIT_ZERO=1).
// Reference model: flat 64-word memory, queue of expected responses tagged
// with their acceptance cycle, and a count of outstanding reads.
// -----------------------------------------------------------------------------
module tb_sram_banked_wrapper;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int INITC = 16;   // 2**MACRO_ADDR_W init cycles
   localparam int LAT   = 3;    // read latency into an empty FIFO

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          ready;
   logic [AW-1:0] addr = '0;
   logic          wmode = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [1:0]    wmask = '0;
   logic          rvalid;
   logic          rready = 1'b0;
   logic [DW-1:0] rdata;
   logic          init_done;

   always #5 clk = ~clk;

   sram_banked_wrapper #(
      .ADDR_W(6), .DATA_W(32), .MACRO_ADDR_W(4), .MACRO_DATA_W(16),
      .RSP_DEPTH(4), .INIT_ZERO(1)
   ) dut (
      .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_en(en), .RW0_ready(ready),
      .RW0_addr(addr), .RW0_wmode(wmode), .RW0_wdata(wdata), .RW0_wmask(wmask),
      .RW0_rvalid(rvalid), .RW0_rready(rready), .RW0_rdata(rdata),
      .init_done(init_done)
   );

   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } rsp_t;

   typedef struct {
      bit            wm;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0]    m;
      logic [DW-1:0] exp;
      string         nm;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] mem_m [64];
   rsp_t          rq [$];
   int            outstanding = 0;
   int            cyc = 0;
   int            rel_cyc = 0;
   bit            hold_prev = 0;
   logic [DW-1:0] hold_data = '0;
   bit            acc_last, pop_last;
   logic [DW-1:0] pop_data;
   int            pop_cyc, acc_cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Called at a negedge; drives one cycle of inputs, checks outputs against
   // the model, updates the model with the handshakes, returns at the next negedge.
   task automatic step(input bit e, input bit wm, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [1:0] m, input bit rr);
      int   k;
      bit   exp_rdy, exp_rv;
      rsp_t r;
      en = e; wmode = wm; addr = a; wdata = wd; wmask = m; rready = rr;
      #1;
      k       = cyc - rel_cyc;
      exp_rdy = (k >= INITC) && (outstanding < DEPTH);
      exp_rv  = (rq.size() > 0) && (rq[0].t + LAT <= cyc);
      chk("ready", 32'(ready), 32'(exp_rdy));
      chk("init_done", 32'(init_done), 32'(k >= INITC + 1));
      chk("rvalid", 32'(rvalid), 32'(exp_rv));
      if (hold_prev && rvalid) chk("rdata_hold", rdata, hold_data);
      acc_last = e & ready;
      pop_last = rvalid & rr;
      if (pop_last && rq.size() > 0) begin
         pop_data = rdata;
         pop_cyc  = cyc;
         r = rq.pop_front();
         chk("rdata", rdata, r.d);
         outstanding--;
      end
      if (acc_last) begin
         acc_cyc = cyc;
         if (wm) begin
            for (int c = 0; c < 2; c++)
               if (m[c]) mem_m[a][c*16 +: 16] = wd[c*16 +: 16];
         end else begin
            rq.push_back('{mem_m[a], cyc});
            outstanding++;
         end
      end
      hold_prev = rvalid & ~rr;
      hold_data = rdata;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 1'b0, '0, '0, 2'b00, rr);
   endtask

   // Called at a negedge; asserts reset, checks reset values, releases.
   task automatic do_reset();
      en = 1'b0; rready = 1'b0; rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      rq.delete();
      outstanding = 0;
      hold_prev   = 0;
      for (int i = 0; i < 64; i++) mem_m[i] = '0;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      rel_cyc = cyc;
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!ready && n < 40) begin
         idle(1'b1);
         n++;
      end
      chk("init_len", 32'(n), 32'(INITC));
      chk("init_done_lag", 32'(init_done), 32'd0);
      idle(1'b1);
      chk("init_done_up", 32'(init_done), 32'd1);
   endtask

   task automatic write_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
      int n;
      n = 0;
      acc_last = 0;
      while (!acc_last && n < 20) begin
         step(1'b1, 1'b1, a, d, m, 1'b1);
         n++;
      end
      chk("wr_accept", 32'(acc_last), 32'd1);
   endtask

   task automatic read_expect(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
      int n;
      n = 0;
      acc_last = 0;
      while (!acc_last && n < 20) begin
         step(1'b1, 1'b0, a, '0, 2'b00, 1'b1);
         n++;
      end
      chk({nm, "_accept"}, 32'(acc_last), 32'd1);
      n = 0;
      pop_last = 0;
      while (!pop_last && n < 10) begin
         idle(1'b1);
         n++;
      end
      chk({nm, "_popped"}, 32'(pop_last), 32'd1);
      chk(nm, pop_data, exp);
      chk({nm, "_lat"}, 32'(pop_cyc - acc_cyc), 32'(LAT));
   endtask

   vec_t          vt [10];
   logic [DW-1:0] got [$];
   int            nacc;

   initial begin
      vt[0] = '{1'b0, 6'h3F, 32'h0,        2'b00, 32'h00000000, "init_zero_3f"};
      vt[1] = '{1'b1, 6'h12, 32'hDEADBEEF, 2'b11, 32'h0,        "wr"};
      vt[2] = '{1'b0, 6'h12, 32'h0,        2'b00, 32'hDEADBEEF, "rd_full"};
      vt[3] = '{1'b1, 6'h12, 32'h0000CAFE, 2'b01, 32'h0,        "wr"};
      vt[4] = '{1'b0, 6'h12, 32'h0,        2'b00, 32'hDEADCAFE, "rd_mask_lo"};
      vt[5] = '{1'b0, 6'h02, 32'h0,        2'b00, 32'h00000000, "rd_other_row"};
      vt[6] = '{1'b1, 6'h25, 32'h12345678, 2'b10, 32'h0,        "wr"};
      vt[7] = '{1'b0, 6'h25, 32'h0,        2'b00, 32'h12340000, "rd_mask_hi"};
      vt[8] = '{1'b1, 6'h35, 32'hAAAA5555, 2'b00, 32'h0,        "wr"};
      vt[9] = '{1'b0, 6'h35, 32'h0,        2'b00, 32'h00000000, "rd_mask_none"};

      @(negedge clk);
      do_reset();
      wait_init();

      // Directed table
      for (int i = 0; i < 10; i++) begin
         if (vt[i].wm) write_op(vt[i].a, vt[i].d, vt[i].m);
         else          read_expect(vt[i].a, vt[i].exp, vt[i].nm);
      end

      // Back-pressure: six reads with rready low, then accept+pop at full credit
      for (int i = 0; i < 6; i++) write_op(6'(8 + i), 32'hA5A50000 | 32'(i), 2'b11);
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 6'(8 + nacc), '0, 2'b00, 1'b0);
         if (acc_last) nacc++;
      end
      chk("bp_accepts", 32'(nacc), 32'(DEPTH));
      chk("bp_ready_low", 32'(ready), 32'd0);
      repeat (3) step(1'b1, 1'b0, 6'(8 + nacc), '0, 2'b00, 1'b0);
      got.delete();
      step(1'b1, 1'b0, 6'(8 + nacc), '0, 2'b00, 1'b1);
      chk("full_no_accept", 32'(acc_last), 32'd0);
      chk("full_pop", 32'(pop_last), 32'd1);
      if (pop_last) got.push_back(pop_data);
      for (int n = 0; n < 60 && got.size() < 6; n++) begin
         step(nacc < 6, 1'b0, 6'(8 + nacc), '0, 2'b00, 1'b1);
         if (acc_last) nacc++;
         if (pop_last) got.push_back(pop_data);
      end
      chk("bp_rsp_count", 32'(got.size()), 32'd6);
      for (int i = 0; i < 6 && i < got.size(); i++)
         chk("bp_order", got[i], 32'hA5A50000 | 32'(i));

      // Randomised traffic against the model
      for (int n = 0; n < 600; n++) begin
         step(($urandom % 4) != 0, $urandom % 2, 6'($urandom % 64), $urandom,
              2'($urandom % 4), ($urandom % 4) != 0);
      end
      for (int n = 0; n < 40 && (rq.size() > 0 || rvalid); n++) idle(1'b1);
      chk("drain", 32'(rq.size()), 32'd0);

      // Reset with reads in flight
      write_op(6'h12, 32'h600DF00D, 2'b11);
      repeat (3) step(1'b1, 1'b0, 6'h12, '0, 2'b00, 1'b0);
      idle(1'b0);
      chk("pre_reset_rvalid", 32'(rvalid), 32'd1);
      do_reset();
      wait_init();
      read_expect(6'h12, 32'h0, "post_reset_zero");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
